// File: rtl/lsu_axi_master.sv
// Load/store unit AXI-lite style master.
// Accepts one pipeline access at a time, issues it on the AXI read or write
// channels, and reports completion with a single-cycle response pulse.
// A per-transaction cycle counter aborts a stalled access with an error.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a new request; latches the access on req_valid
// RD    | AR issued until accepted, R accepted whenever it arrives
// WR    | AW and W issued together, B accepted at any time
// RESP  | one-cycle completion pulse with captured data / error flag
module lsu_axi_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_len,
    input  logic        req_unsign,

    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,

    output logic        arvalid,
    output logic [31:0] araddr,
    output logic        load_unsign,
    input  logic        arready,

    input  logic        rvalid,
    input  logic [31:0] rdata,
    input  logic        rresp,
    output logic        rready,

    output logic        awvalid,
    output logic [31:0] awaddr,
    input  logic        awready,

    output logic        wvalid,
    output logic [31:0] wdata,
    output logic [31:0] len,
    input  logic        wready,

    input  logic        bvalid,
    output logic        bready
);

    // Counter only has to hold 0 .. TIMEOUT-1; the transition out of RD/WR
    // happens on the edge where it would reach TIMEOUT.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      len_q;
    logic             unsign_q;
    logic [31:0]      rdata_q;
    logic             err_q;
    logic             ar_done;
    logic             aw_done;
    logic             w_done;
    logic             b_done;
    logic [CNT_W-1:0] cnt;

    logic accept;
    logic ar_hs;
    logic r_hs;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic wr_all;
    logic busy;
    logic tmo;

    // Handshake and completion terms shared by the FSM and the datapath.
    always_comb begin
        accept = (state == S_IDLE) && req_valid;
        ar_hs  = arvalid && arready;
        r_hs   = rvalid && rready;
        aw_hs  = awvalid && awready;
        w_hs   = wvalid && wready;
        b_hs   = bvalid && bready;
        // Handshakes in the current cycle count toward write completion.
        wr_all = (aw_done || aw_hs) && (w_done || w_hs) && (b_done || b_hs);
        busy   = (state == S_RD) || (state == S_WR);
        tmo    = busy && (cnt == CNT_LAST);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a completing handshake takes priority over timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_nxt = req_wen ? S_WR : S_RD;
                end
            end
            S_RD: begin
                if (r_hs || tmo) begin
                    state_nxt = S_RESP;
                end
            end
            S_WR: begin
                if (wr_all || tmo) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Channel valids/readies and the response pulse, decoded from state.
    // req_ready is also gated by reset so nothing is offered while held.
    always_comb begin
        req_ready  = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        resp_err   = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = !reset;
            end
            S_RD: begin
                arvalid = !ar_done;
                rready  = 1'b1;
            end
            S_WR: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                bready  = 1'b1;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    // Request latch, channel-done flags, timeout counter and result capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            len_q    <= 32'd0;
            unsign_q <= 1'b0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
            ar_done  <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            b_done   <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        len_q    <= req_len;
                        unsign_q <= req_unsign;
                        rdata_q  <= 32'd0;
                        err_q    <= 1'b0;
                        ar_done  <= 1'b0;
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                        b_done   <= 1'b0;
                        cnt      <= '0;
                    end
                end
                S_RD: begin
                    cnt <= cnt + 1'b1;
                    if (ar_hs) begin
                        ar_done <= 1'b1;
                    end
                    if (r_hs) begin
                        rdata_q <= rdata;
                        err_q   <= !rresp;
                    end else if (tmo) begin
                        rdata_q <= 32'd0;
                        err_q   <= 1'b1;
                    end
                end
                S_WR: begin
                    cnt <= cnt + 1'b1;
                    if (aw_hs) begin
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        w_done <= 1'b1;
                    end
                    if (b_hs) begin
                        b_done <= 1'b1;
                    end
                    rdata_q <= 32'd0;
                    if (wr_all) begin
                        err_q <= 1'b0;
                    end else if (tmo) begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

    assign araddr      = addr_q;
    assign awaddr      = addr_q;
    assign wdata       = wdata_q;
    assign len         = len_q;
    assign load_unsign = unsign_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Bench for lsu_axi_master: directed cases plus randomized slave latencies,
// with expected timing/results derived from per-channel latencies.
module tb_lsu_axi_master;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wen, req_unsign;
    logic [31:0] req_addr, req_wdata, req_len;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        arvalid, load_unsign, arready;
    logic [31:0] araddr;
    logic        rvalid, rresp, rready;
    logic [31:0] rdata;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic        wvalid, wready;
    logic [31:0] wdata, len;
    logic        bvalid, bready;

    int checks   = 0;
    int failures = 0;

    lsu_axi_master #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .req_unsign(req_unsign),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .arvalid(arvalid), .araddr(araddr), .load_unsign(load_unsign), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
        .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .len(len), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_slave();
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    endtask

    task automatic scramble_req();
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_len    = $urandom;
        req_unsign = 1'($urandom_range(0, 1));
        req_wen    = 1'($urandom_range(0, 1));
    endtask

    task automatic check_all_quiet(input string tag);
        chk1({tag, "_arvalid"}, arvalid, 1'b0);
        chk1({tag, "_rready"}, rready, 1'b0);
        chk1({tag, "_awvalid"}, awvalid, 1'b0);
        chk1({tag, "_wvalid"}, wvalid, 1'b0);
        chk1({tag, "_bready"}, bready, 1'b0);
        chk1({tag, "_resp_valid"}, resp_valid, 1'b0);
        chk1({tag, "_resp_err"}, resp_err, 1'b0);
        chk1({tag, "_req_ready"}, req_ready, 1'b0);
        chk32({tag, "_araddr"}, araddr, 32'd0);
        chk32({tag, "_awaddr"}, awaddr, 32'd0);
        chk32({tag, "_wdata"}, wdata, 32'd0);
        chk32({tag, "_len"}, len, 32'd0);
    endtask

    // Slave answers AR at cycle ar_lat and R at cycle r_lat (cycles counted
    // from the first RD cycle). The access ends in the cycle R is taken, or
    // after TMO cycles with an error if R never comes in time.
    task automatic do_load(input logic [31:0] addr, input logic [31:0] ln, input logic uns,
                           input logic [31:0] rd, input logic rr,
                           input int ar_lat, input int r_lat);
        bit          timed;
        int          idx;
        logic        exp_err;
        logic [31:0] exp_rd;
        timed   = (r_lat > TMO - 1);
        idx     = timed ? TMO : r_lat + 1;
        exp_err = timed ? 1'b1 : !rr;
        exp_rd  = timed ? 32'd0 : rd;
        chk1("ld_req_ready", req_ready, 1'b1);
        req_valid = 1'b1; req_wen = 1'b0; req_addr = addr; req_len = ln;
        req_unsign = uns; req_wdata = $urandom;
        tick();
        scramble_req();
        for (int k = 0; k <= idx; k++) begin
            if (k == idx) begin
                idle_slave();
                #1;
                chk1("ld_resp_valid", resp_valid, 1'b1);
                chk32("ld_resp_rdata", resp_rdata, exp_rd);
                chk1("ld_resp_err", resp_err, exp_err);
                chk1("ld_resp_arvalid", arvalid, 1'b0);
                chk1("ld_resp_rready", rready, 1'b0);
            end else begin
                arready = (k >= ar_lat);
                rvalid  = (k >= r_lat);
                rdata   = rd;
                rresp   = rr;
                #1;
                chk1("ld_busy_resp_valid", resp_valid, 1'b0);
                chk1("ld_busy_req_ready", req_ready, 1'b0);
                chk1("ld_arvalid", arvalid, k <= ar_lat);
                chk1("ld_rready", rready, 1'b1);
                chk1("ld_awvalid", awvalid, 1'b0);
                chk32("ld_araddr", araddr, addr);
                chk32("ld_len", len, ln);
                chk1("ld_load_unsign", load_unsign, uns);
                tick();
            end
        end
        tick();
        chk1("ld_single_pulse", resp_valid, 1'b0);
        chk1("ld_back_idle", req_ready, 1'b1);
    endtask

    // AW, W and B each complete at their own latency; the store finishes in
    // the cycle the last of the three is taken, or times out at TMO cycles.
    task automatic do_store(input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] ln,
                            input int aw_lat, input int w_lat, input int b_lat);
        int   last;
        bit   timed;
        int   idx;
        last  = aw_lat;
        if (w_lat > last) last = w_lat;
        if (b_lat > last) last = b_lat;
        timed = (last > TMO - 1);
        idx   = timed ? TMO : last + 1;
        chk1("st_req_ready", req_ready, 1'b1);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = addr; req_wdata = wd;
        req_len = ln; req_unsign = 1'($urandom_range(0, 1));
        tick();
        scramble_req();
        for (int k = 0; k <= idx; k++) begin
            if (k == idx) begin
                idle_slave();
                #1;
                chk1("st_resp_valid", resp_valid, 1'b1);
                chk32("st_resp_rdata", resp_rdata, 32'd0);
                chk1("st_resp_err", resp_err, timed);
                chk1("st_resp_awvalid", awvalid, 1'b0);
                chk1("st_resp_bready", bready, 1'b0);
            end else begin
                awready = (k >= aw_lat);
                wready  = (k >= w_lat);
                bvalid  = (k >= b_lat);
                #1;
                chk1("st_busy_resp_valid", resp_valid, 1'b0);
                chk1("st_busy_req_ready", req_ready, 1'b0);
                chk1("st_awvalid", awvalid, k <= aw_lat);
                chk1("st_wvalid", wvalid, k <= w_lat);
                chk1("st_bready", bready, 1'b1);
                chk1("st_arvalid", arvalid, 1'b0);
                chk32("st_awaddr", awaddr, addr);
                chk32("st_wdata", wdata, wd);
                chk32("st_len", len, ln);
                tick();
            end
        end
        tick();
        chk1("st_single_pulse", resp_valid, 1'b0);
        chk1("st_back_idle", req_ready, 1'b1);
    endtask

    initial begin
        int ln_sel;
        int al, rl;
        logic [31:0] lens [3];
        lens[0] = 32'd1; lens[1] = 32'd2; lens[2] = 32'd4;

        reset = 1'b1;
        idle_slave();
        req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'd0;
        req_wdata = 32'd0; req_len = 32'd0; req_unsign = 1'b0;
        tick();
        tick();
        check_all_quiet("rst");
        reset = 1'b0;
        #1;
        chk1("rst_release_req_ready", req_ready, 1'b1);
        tick();

        // Basic load: AR accepted at once, R two cycles later.
        do_load(32'h8000_0010, 32'd4, 1'b0, 32'hDEAD_BEEF, 1'b1, 0, 2);
        // Basic store: AW one cycle late, W and B together.
        do_store(32'h8000_0020, 32'h1234_5678, 32'd2, 1, 2, 2);
        // B arrives before AW is accepted.
        do_store(32'h8000_0040, 32'hCAFE_F00D, 32'd4, 3, 1, 0);
        // Slave error on the read.
        do_load(32'h8000_0050, 32'd1, 1'b1, 32'h0000_00A5, 1'b0, 0, 1);
        // Slave never answers the read.
        do_load(32'h8000_0060, 32'd2, 1'b0, 32'h5555_5555, 1'b1, 100, 100);
        // Read data lands in the last cycle before timeout.
        do_load(32'h8000_0070, 32'd4, 1'b1, 32'h0BAD_F00D, 1'b1, 3, TMO - 1);
        // Write completes in the last cycle before timeout, and a write timeout.
        do_store(32'h8000_0080, 32'h1111_2222, 32'd1, TMO - 1, 2, 0);
        do_store(32'h8000_0090, 32'h3333_4444, 32'd4, 2, TMO, 1);
        // Unchecked length values pass straight through.
        do_load(32'h8000_00A0, 32'h0000_0055, 1'b0, 32'h7777_8888, 1'b1, 1, 1);

        // Reset in the middle of a write.
        chk1("mid_req_ready", req_ready, 1'b1);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_00B0;
        req_wdata = 32'hA5A5_5A5A; req_len = 32'd4;
        tick();
        scramble_req();
        tick();
        chk1("mid_wvalid_before_reset", wvalid, 1'b1);
        reset = 1'b1;
        #1;
        check_all_quiet("mid_rst");
        tick();
        chk1("mid_rst_no_resp", resp_valid, 1'b0);
        reset = 1'b0;
        #1;
        chk1("mid_rst_req_ready", req_ready, 1'b1);
        tick();
        chk1("mid_rst_no_late_resp", resp_valid, 1'b0);
        do_load(32'h8000_00C0, 32'd4, 1'b0, 32'hFEED_FACE, 1'b1, 0, 1);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            ln_sel = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) begin
                do_store($urandom, $urandom, lens[ln_sel],
                         $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
            end else begin
                al = $urandom_range(0, 4);
                rl = al + $urandom_range(0, 6);
                do_load($urandom, lens[ln_sel], 1'($urandom_range(0, 1)), $urandom,
                        1'($urandom_range(0, 3) != 0), al, rl);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
